mem_arbiter: RTL

Shares the SISC single-port main memory between the instruction-fetch path and the load/store data path. Each requester uses a req/ack handshake. The arbiter picks one request per transaction, drives the memory port for one issue cycle and waits a fixed read latency. It then returns read data with a one-cycle ack pulse. It sits between the fetch/IR-load logic, the LOD/STR datapath and the memory model, and `ctrl` sequences it through the requesters' `req` lines.

---
 rtl/mem_arbiter.sv | 132 +++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single-port main memory between instruction fetch
// and the load/store data path. One transaction at a time:
// IDLE -> ISSUE -> WAIT (MEM_LAT cycles) -> ACK -> IDLE.
// Optional build macro MEM_ARB_RR_EN: round-robin on simultaneous requests.
// Without it, data always wins a tie.
module mem_arbiter #(
    parameter int DW      = 32,
    parameter int AW      = 16,
    parameter int MEM_LAT = 2    // legal range 1..15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_ack,
    output logic [DW-1:0] if_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic [DW-1:0] d_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        ACK   = 2'd3
    } state_t;

    localparam logic       OWN_IF = 1'b0;
    localparam logic       OWN_D  = 1'b1;
    localparam logic [3:0] LAT    = 4'(MEM_LAT);

    state_t     state;
    logic       owner;      // requester being served in this transaction
    logic       lat_we;     // latched write enable of the winner
    logic [3:0] wait_cnt;
    logic       grant_d;    // 1 when the data path wins arbitration in IDLE

`ifdef MEM_ARB_RR_EN
    logic last_owner;

    // Tie goes to whichever requester was not served last
    assign grant_d = d_req && (!if_req || (last_owner == OWN_IF));
`else
    // Fixed priority: data wins every tie
    assign grant_d = d_req;
`endif

    assign busy = (state != IDLE);

    // Transaction sequencer with registered memory-port and handshake outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            owner     <= OWN_IF;
            lat_we    <= 1'b0;
            wait_cnt  <= 4'd0;
            if_ack    <= 1'b0;
            d_ack     <= 1'b0;
            if_rdata  <= '0;
            d_rdata   <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
`ifdef MEM_ARB_RR_EN
            last_owner <= OWN_IF;
`endif
        end else begin
            // NOTE: non-blocking assignments throughout; these defaults make
            // every pulse output drop after one cycle unless re-asserted below.
            if_ack    <= 1'b0;
            d_ack     <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;

            case (state)
                IDLE: begin
                    if (if_req || d_req) begin
                        // The memory-port registers hold the latched address
                        // and write data for the ISSUE cycle.
                        owner     <= grant_d ? OWN_D : OWN_IF;
                        lat_we    <= grant_d && d_we;
                        mem_en    <= 1'b1;
                        mem_we    <= grant_d && d_we;
                        mem_addr  <= grant_d ? d_addr : if_addr;
                        mem_wdata <= grant_d ? d_wdata : '0;
`ifdef MEM_ARB_RR_EN
                        last_owner <= grant_d ? OWN_D : OWN_IF;
`endif
                        state     <= ISSUE;
                    end
                end

                ISSUE: begin
                    wait_cnt <= LAT;
                    state    <= WAIT;
                end

                WAIT: begin
                    wait_cnt <= wait_cnt - 4'd1;
                    if (wait_cnt == 4'd1) begin
                        // Read data is valid on this cycle; stores capture nothing
                        if (!lat_we) begin
                            if (owner == OWN_D) d_rdata  <= mem_rdata;
                            else                if_rdata <= mem_rdata;
                        end
                        if (owner == OWN_D) d_ack  <= 1'b1;
                        else                if_ack <= 1'b1;
                        state <= ACK;
                    end
                end

                ACK: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
